fc_input_packer: RTL

- Producer side of the FC layer's input-vector interface.
- Collects pooled feature-map values arriving as a stream of IN_LANES channel values per beat. Packs them channel-major into one FC_IN_VEC-wide flattened vector.
- Presents the vector with a single-cycle valid pulse to the fully-connected matrix-multiply stage, which samples vector and valid in the same cycle.
- Sits between the last pooling stage and the FC layer.

---
 rtl/fc_input_packer_pkg.sv | 19 +
 rtl/fc_pack_beat_ctr.sv | 74 +++++++
 rtl/fc_input_packer.sv | 76 +++++++
 3 files changed

// File: rtl/fc_input_packer_pkg.sv
// Shared FC-stage definitions: default geometry and the packer state encoding.
// Optional frame-framing check is enabled by defining FC_PACK_LAST_CHECK_EN.
package fc_input_packer_pkg;

    localparam int DEF_OF_BW     = 8;
    localparam int DEF_FC_IN_VEC = 48;
    localparam int DEF_IN_LANES  = 3;   // CNN output channels (CO)

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } pack_state_t;

    // Counter width that stays legal for a single-position frame.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_pack_beat_ctr.sv
// Beat counter for the FC input packer: beat index, wrap/emit strobe, EMIT state.
// With FC_PACK_LAST_CHECK_EN defined, i_in_last is checked and a sticky error kept.
module fc_pack_beat_ctr
    import fc_input_packer_pkg::*;
#(
    parameter int POSITIONS = 16,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             clear,
    output logic [CNT_W-1:0] beat_idx,
    output logic             emit_stb,
    output pack_state_t      state,
    output logic             err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(POSITIONS - 1);

    logic [CNT_W-1:0] cnt_reg;
    pack_state_t      state_reg;
    logic             accept;
    logic             final_beat;
    logic             early_last;

    // Clear takes priority over a coincident beat, including the final one.
    assign accept     = in_valid & ~clear;
    assign final_beat = (cnt_reg == LAST_IDX);
    assign emit_stb   = accept & final_beat;

`ifdef FC_PACK_LAST_CHECK_EN
    logic err_reg;
    logic missing_last;

    assign early_last   = accept & in_last & ~final_beat;
    assign missing_last = accept & ~in_last & final_beat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_reg <= 1'b0;
        end else if (early_last || missing_last) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    logic unused_last;

    assign unused_last = in_last;
    assign early_last  = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            state_reg <= FILL;
        end else begin
            state_reg <= emit_stb ? EMIT : FILL;
            if (clear || (accept && (final_beat || early_last))) begin
                cnt_reg <= '0;
            end else if (accept) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign beat_idx = cnt_reg;
    assign state    = state_reg;

endmodule

// File: rtl/fc_input_packer.sv
// Packs IN_LANES-wide pooled beats channel-major into one FC input vector.
// Define FC_PACK_LAST_CHECK_EN to enable i_in_last framing checks (o_err).
module fc_input_packer
    import fc_input_packer_pkg::*;
#(
    parameter  int IN_LANES  = DEF_IN_LANES,
    parameter  int FC_IN_VEC = DEF_FC_IN_VEC,
    parameter  int OF_BW     = DEF_OF_BW,
    localparam int POSITIONS = FC_IN_VEC / IN_LANES,
    localparam int CNT_W     = cnt_width(POSITIONS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_in_valid,
    input  logic [IN_LANES*OF_BW-1:0]  i_in_data,
    input  logic                       i_in_last,
    input  logic                       i_clear,
    output logic                       o_ot_valid,
    output logic [FC_IN_VEC*OF_BW-1:0] o_ot_fmap,
    output logic [CNT_W-1:0]           o_beat_cnt,
    output logic                       o_err
);

    logic [FC_IN_VEC*OF_BW-1:0] fill_reg;
    logic [FC_IN_VEC*OF_BW-1:0] fill_next;
    logic [CNT_W-1:0]           beat_idx;
    logic                       emit_stb;
    logic                       accept;
    pack_state_t                state;

    fc_pack_beat_ctr #(
        .POSITIONS (POSITIONS),
        .CNT_W     (CNT_W)
    ) u_beat_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (i_in_valid),
        .in_last  (i_in_last),
        .clear    (i_clear),
        .beat_idx (beat_idx),
        .emit_stb (emit_stb),
        .state    (state),
        .err      (o_err)
    );

    assign accept = i_in_valid & ~i_clear;

    // Lane gi of beat gj lands at element gi*POSITIONS + gj.
    generate
        for (genvar gi = 0; gi < IN_LANES; gi++) begin : g_lane
            for (genvar gj = 0; gj < POSITIONS; gj++) begin : g_pos
                assign fill_next[(gi*POSITIONS+gj)*OF_BW +: OF_BW] =
                    (accept && (beat_idx == CNT_W'(gj)))
                        ? i_in_data[gi*OF_BW +: OF_BW]
                        : fill_reg[(gi*POSITIONS+gj)*OF_BW +: OF_BW];
            end
        end
    endgenerate

    // The output register loads the merged vector so the final beat needs no extra cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_reg  <= '0;
            o_ot_fmap <= '0;
        end else begin
            fill_reg <= fill_next;
            if (emit_stb) begin
                o_ot_fmap <= fill_next;
            end
        end
    end

    assign o_ot_valid = (state == EMIT);
    assign o_beat_cnt = beat_idx;

endmodule
